// File: rtl/faddn_pkg.sv
// Shared definitions for the pipelined N-bit adder/subtractor family.
package faddn_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } opmode_t;

    // True when the width/stage combination can be split into equal slices.
    function automatic bit params_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/fadd_slice.sv
// Combinational ripple of SLICE full-adder bits; one of these per pipeline stage.
module fadd_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < SLICE; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[SLICE];
        cmsb = carry[SLICE - 1];
    end

endmodule

// File: rtl/faddn_pipe.sv
// Pipelined WIDTH-bit adder/subtractor: one SLICE-bit ripple per stage, carry
// registered between stages, valid tracking, global stall and signed overflow.
module faddn_pipe
    import faddn_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IV,
    input  logic             HOLD,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CI,
    output logic [WIDTH-1:0] S,
    output logic             CO,
    output logic             OV,
    output logic             OVLD
);

    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("faddn_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end

    opmode_t          mode;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Stage k registers: operands still to be consumed, carry from stage k-1,
    // the sum bits already produced below slice k, and the valid bit.
    logic [WIDTH-1:0] opa_q  [STAGES];
    logic [WIDTH-1:0] opb_q  [STAGES];
    logic [WIDTH-1:0] part_q [STAGES];
    logic             cin_q  [STAGES];
    logic             vld_q  [STAGES];

    logic [SLICE-1:0] slice_sum [STAGES];
    logic             slice_co  [STAGES];
    logic             slice_cm  [STAGES];
    logic [WIDTH-1:0] merged    [STAGES];

    always_comb begin
        mode  = SUB ? OP_SUB : OP_ADD;
        b_eff = (mode == OP_SUB) ? ~B : B;
        cin0  = (mode == OP_SUB) ? 1'b1 : CI;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        fadd_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a    (opa_q[k][k*SLICE +: SLICE]),
            .b    (opb_q[k][k*SLICE +: SLICE]),
            .cin  (cin_q[k]),
            .sum  (slice_sum[k]),
            .cout (slice_co[k]),
            .cmsb (slice_cm[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            merged[k] = part_q[k];
            merged[k][k*SLICE +: SLICE] = slice_sum[k];
        end
    end

    // HOLD freezes every register; results only overwrite S/CO/OV when valid.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                opa_q[k]  <= '0;
                opb_q[k]  <= '0;
                part_q[k] <= '0;
                cin_q[k]  <= 1'b0;
                vld_q[k]  <= 1'b0;
            end
            S    <= '0;
            CO   <= 1'b0;
            OV   <= 1'b0;
            OVLD <= 1'b0;
        end else if (!HOLD) begin
            opa_q[0]  <= A;
            opb_q[0]  <= b_eff;
            part_q[0] <= '0;
            cin_q[0]  <= cin0;
            vld_q[0]  <= IV;
            for (int k = 1; k < STAGES; k++) begin
                opa_q[k]  <= opa_q[k-1];
                opb_q[k]  <= opb_q[k-1];
                part_q[k] <= merged[k-1];
                cin_q[k]  <= slice_co[k-1];
                vld_q[k]  <= vld_q[k-1];
            end
            OVLD <= vld_q[LAST];
            if (vld_q[LAST]) begin
                S  <= merged[LAST];
                CO <= slice_co[LAST];
                OV <= slice_co[LAST] ^ slice_cm[LAST];
            end
        end
    end

endmodule

// File: tb/tb_faddn_pipe.sv
// Directed self-checking bench for faddn_pipe at WIDTH=16, STAGES=4.
module tb_faddn_pipe;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IV;
    logic        HOLD;
    logic        SUB;
    logic [15:0] A;
    logic [15:0] B;
    logic        CI;
    logic [15:0] S;
    logic        CO;
    logic        OV;
    logic        OVLD;

    int errors = 0;
    int checks = 0;

    // Stall scenario: operation index presented before each edge (-1 = idle).
    int          op_sel   [12] = '{0, 1, 2, 2, 2, 3, -1, -1, -1, -1, -1, -1};
    bit          hold_sel [12] = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [15:0] op_a     [4]  = '{16'h0001, 16'h0100, 16'hF000, 16'h0010};
    logic [15:0] op_b     [4]  = '{16'h0001, 16'h0200, 16'h1000, 16'h0001};
    bit          op_sub   [4]  = '{0, 0, 0, 1};
    logic [15:0] exp_s    [4]  = '{16'h0002, 16'h0300, 16'h0000, 16'h000F};
    bit          exp_co   [4]  = '{0, 0, 1, 1};

    faddn_pipe #(
        .WIDTH  (16),
        .STAGES (4)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .IV   (IV),
        .HOLD (HOLD),
        .SUB  (SUB),
        .A    (A),
        .B    (B),
        .CI   (CI),
        .S    (S),
        .CO   (CO),
        .OV   (OV),
        .OVLD (OVLD)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit iv, input bit hold, input bit sub,
                                 input logic [15:0] a, input logic [15:0] b, input bit ci);
        IV   = iv;
        HOLD = hold;
        SUB  = sub;
        A    = a;
        B    = b;
        CI   = ci;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Single isolated operation: exact latency of 4 edges, one-cycle OVLD, S held after.
    task automatic runSingle(input string tag, input bit sub, input logic [15:0] a,
                             input logic [15:0] b, input bit ci, input logic [15:0] es,
                             input bit eco, input bit eov);
        applyStimulus(1, 0, sub, a, b, ci);
        tick();
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 1; i < 4; i++) begin
            tick();
            checkOutput({tag, "_ovld_early"}, OVLD, 0);
        end
        tick();
        checkOutput({tag, "_ovld"}, OVLD, 1);
        checkOutput({tag, "_s"}, S, es);
        checkOutput({tag, "_co"}, CO, eco);
        checkOutput({tag, "_ov"}, OV, eov);
        tick();
        checkOutput({tag, "_ovld_drop"}, OVLD, 0);
        checkOutput({tag, "_s_hold"}, S, es);
    endtask

    initial begin
        RST = 1'b1;
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 1'($urandom),
                          16'($urandom), 16'($urandom), 1'($urandom));
            tick();
            checkOutput("rst_s", S, 16'h0000);
            checkOutput("rst_co", CO, 0);
            checkOutput("rst_ov", OV, 0);
            checkOutput("rst_ovld", OVLD, 0);
        end
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("idle_ovld", OVLD, 0);
        end

        runSingle("add_basic", 0, 16'h1234, 16'h4321, 0, 16'h5555, 0, 0);
        runSingle("add_ripple", 0, 16'hFFFF, 16'h0000, 1, 16'h0000, 1, 0);
        runSingle("add_ovf", 0, 16'h7FFF, 16'h0001, 0, 16'h8000, 0, 1);
        runSingle("sub_neg", 1, 16'h0003, 16'h0005, 1, 16'hFFFE, 0, 0);
        runSingle("sub_ovf", 1, 16'h8000, 16'h0001, 0, 16'h7FFF, 1, 1);

        // Four back-to-back ops, HOLD for two cycles after the second is accepted.
        for (int c = 0; c < 12; c++) begin
            if (op_sel[c] >= 0)
                applyStimulus(1, hold_sel[c], op_sub[op_sel[c]], op_a[op_sel[c]],
                              op_b[op_sel[c]], 0);
            else
                applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
            tick();
            checkOutput("stall_ovld", OVLD, (c >= 6 && c <= 9) ? 1 : 0);
            if (c >= 6 && c <= 9) begin
                checkOutput("stall_s", S, exp_s[c-6]);
                checkOutput("stall_co", CO, exp_co[c-6]);
                checkOutput("stall_ov", OV, 0);
            end
        end

        // HOLD while a result is on the output: OVLD stays high, stalled input is dropped.
        applyStimulus(1, 0, 1, 16'h8000, 16'h0001, 0);
        tick();
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 1; i < 4; i++) tick();
        tick();
        checkOutput("hold_out_ovld", OVLD, 1);
        checkOutput("hold_out_s", S, 16'h7FFF);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1, 0, 16'h1111, 16'h1111, 0);
            tick();
            checkOutput("hold_frozen_ovld", OVLD, 1);
            checkOutput("hold_frozen_s", S, 16'h7FFF);
        end
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("hold_no_dup_ovld", OVLD, 0);
            checkOutput("hold_no_dup_s", S, 16'h7FFF);
        end

        // Reset mid-stream with three operations in flight.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 0, 16'h1111 * 16'(i + 1), 16'h0101, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 16'h0000, 16'h0000, 0);
        RST = 1'b1;
        #1;
        checkOutput("async_rst_s", S, 16'h0000);
        checkOutput("async_rst_co", CO, 0);
        checkOutput("async_rst_ov", OV, 0);
        checkOutput("async_rst_ovld", OVLD, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checkOutput("flush_ovld", OVLD, 0);
        end
        runSingle("post_rst", 0, 16'hAAAA, 16'h5555, 0, 16'hFFFF, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/faddn_pipe.md
# faddn_pipe

Parametrised, pipelined N-bit adder/subtractor, successor to the single-bit full-adder cell. Built from ripple slices of full-adder bits, with the carry registered between slices, so the carry chain length per cycle is WIDTH/STAGES bits. Adds valid tracking, a pipeline stall, subtract mode and signed-overflow detection. Used wherever a wide add must close timing at the library's characterised clock rate.

## Interface
- WIDTH, 16: operand and sum width in bits; must be ≥ 2.
- STAGES, 4: pipeline stages; WIDTH % STAGES must be 0; SLICE = WIDTH/STAGES bits per stage.
- CLK  input  1  clock, rising-edge active.
- RST  input  1  reset, asynchronous, active-high.
- IV  input  1  input valid; operands sampled when IV=1 and HOLD=0.
- HOLD  input  1  stall; freezes every pipeline register, including outputs.
- SUB  input  1  0: A+B+CI; 1: A+~B+1 (CI ignored).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CI  input  1  carry-in (add mode only).
- S  output  WIDTH  registered sum/difference.
- CO  output  1  carry-out; in SUB mode 1 = no borrow.
- OV  output  1  signed overflow, two's complement.
- OVLD  output  1  output valid, one pulse per accepted operation.

## Operation
- Stage k (0..STAGES-1) adds bit slice k of A and B' (B' = B or ~B per SUB) plus the carry registered by stage k-1. Stage 0's carry-in is CI (add) or 1 (sub).
- Slice-k operands and SUB are skewed through k input registers; completed sum slices are deskewed so all WIDTH bits of S leave together.
- CO = carry out of the MSB slice. OV = carry into MSB XOR carry out of MSB, computed in the last stage.
- A valid bit travels with each operation. IV=0 inserts a bubble.
- S/CO/OV update only when a valid result reaches the output stage and otherwise hold their last value. OVLD=1 for exactly that cycle (while HOLD=0).
- HOLD=1: no register changes, including data, valid bits and outputs (OVLD keeps its current level). No inputs are accepted. No operation is lost or duplicated.
- STAGES=1: single registered adder, no skew registers.
- A violated parameter rule (WIDTH % STAGES ≠ 0, or WIDTH < 2) is an elaboration-time error.

## Timing
- Reset values: S=0, CO=0, OV=0, OVLD=0. All valid bits and internal carries are 0.
- RST assertion clears all state immediately, including operations in flight. No stale result emerges after RST deasserts.
- Latency: an operation accepted at edge n appears with OVLD=1 after edge n+STAGES, plus one cycle for each cycle HOLD=1 while it is in flight.
- Throughput: one operation per cycle when HOLD=0. Back-to-back results come out in order.
- HOLD and IV asserted in the same cycle: the input is not accepted, and the source must re-present it.

## Structure
- Shared package faddn_pkg:
  - opmode typedef (OP_ADD, OP_SUB).
  - Parameter-check function used by the elaboration assertion.
- One sub-module, fadd_slice: combinational ripple of SLICE full-adder bits. Outputs are the sum slice, carry-out and carry-into-MSB (the last feeds OV). The top level instantiates STAGES of them and owns all registers.

## Test plan
All scenarios use WIDTH=16, STAGES=4.
- Reset: RST=1 with random inputs → S=0x0000, CO=0, OV=0, OVLD=0 throughout. After release with IV=0 → OVLD stays 0.
- Basic add: A=0x1234, B=0x4321, CI=0, IV=1 at edge 0 → after edge 4: OVLD=1, S=0x5555, CO=0, OV=0. OVLD=0 on the next cycle.
- Full carry ripple: A=0xFFFF, B=0x0000, CI=1 → S=0x0000, CO=1, OV=0. Also A=0x7FFF, B=0x0001, CI=0 → S=0x8000, CO=0, OV=1.
- Subtract: SUB=1, A=0x0003, B=0x0005, CI=1 (ignored) → S=0xFFFE, CO=0, OV=0. Also SUB=1, A=0x8000, B=0x0001 → S=0x7FFF, CO=1, OV=1.
- Stall: four consecutive ops with IV=1; HOLD=1 for 2 cycles starting after the second is accepted → four results in order, each latency extended by 2. OVLD stays frozen during HOLD. No duplicates.
- Reset mid-stream: 3 ops in flight, RST pulsed for 1 cycle → outputs cleared asynchronously. No OVLD for the flushed ops. A new op issued after release completes with latency 4.
